// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter and burst sequencer sharing one RAM port among NREQ cache requesters.
// Sequences 1-word IFETCH or 2-word data bursts, with ERROR and watchdog abort.
module mem_rr_arbiter #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    req_type,
  input  logic [32*NREQ-1:0]   req_addr,
  input  logic [1:0]           ramstate,
  output logic [NREQ-1:0]      gnt,
  output logic [1:0]           gnt_type,
  output logic                 beat,
  output logic                 ramREN,
  output logic                 ramWEN,
  output logic [31:0]          ramaddr,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      done,
  output logic                 err
);

  localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned WDW  = $clog2(TIMEOUT) + 1;

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;
  localparam logic [1:0] T_IFETCH  = 2'd0;
  localparam logic [1:0] T_DWRITE  = 2'd2;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDXW-1:0]   win_q, win_d;
  logic [1:0]        type_q, type_d;
  logic [31:0]       addr_q, addr_d;
  logic [WDW-1:0]    wd_cnt_q, wd_cnt_d;

  logic [1:0]        type_arr [NREQ];
  logic [31:0]       addr_arr [NREQ];
  logic [IDXW-1:0]   idx;
  logic [IDXW-1:0]   winner;
  logic              found;
  logic              is_burst;
  logic              unused_addr_lsbs;

  // Word addresses drop the byte offset; the latched low bits are never driven out.
  assign unused_addr_lsbs = ^addr_q[1:0];

  // Unpack the flat requester buses.
  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      type_arr[k] = req_type[2*k +: 2];
      addr_arr[k] = req_addr[32*k +: 32];
    end
  end

  // Rotating scan starting at rr_ptr; first requester found wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = rr_ptr_q + IDXW'(i);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    win_d    = win_q;
    type_d   = type_q;
    addr_d   = addr_q;
    wd_cnt_d = wd_cnt_q;
    gnt      = '0;
    gnt_type = 2'd0;
    beat     = 1'b0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'd0;
    ack      = '0;
    done     = '0;
    err      = 1'b0;
    is_burst = (type_q != T_IFETCH);

    case (state_q)
      IDLE: begin
        wd_cnt_d = '0;
        if (found) begin
          win_d    = winner;
          type_d   = type_arr[winner];
          addr_d   = addr_arr[winner];
          rr_ptr_d = winner + IDXW'(1);
          state_d  = BEAT0;
        end
      end
      BEAT0, BEAT1: begin
        gnt[win_q] = 1'b1;
        gnt_type   = type_q;
        beat       = (state_q == BEAT1);
        ramWEN     = (type_q == T_DWRITE);
        ramREN     = (type_q != T_DWRITE);
        ramaddr    = is_burst ? {addr_q[31:3], beat, 2'b00} : {addr_q[31:2], 2'b00};
        // Hard RAM error or watchdog expiry abandons the transaction without done.
        if ((ramstate == RS_ERROR) ||
            ((ramstate != RS_ACCESS) && (wd_cnt_q == WDW'(TIMEOUT - 1)))) begin
          err      = 1'b1;
          wd_cnt_d = '0;
          state_d  = IDLE;
        end else if (ramstate == RS_ACCESS) begin
          ack[win_q] = 1'b1;
          wd_cnt_d   = '0;
          if ((state_q == BEAT1) || !is_burst) begin
            done[win_q] = 1'b1;
            state_d     = IDLE;
          end else begin
            state_d = BEAT1;
          end
        end else begin
          wd_cnt_d = wd_cnt_q + WDW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      win_q    <= '0;
      type_q   <= 2'd0;
      addr_q   <= 32'd0;
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      win_q    <= win_d;
      type_q   <= type_d;
      addr_q   <= addr_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

endmodule
